// File: rtl/fadd_prep_n40.sv
// Floating-point adder front end: two-stage pipeline that orders the operands by
// magnitude and derives exponent difference, result sign and near/far path routing.
module fadd_prep_n40 #(
   parameter int FRAC_WIDTH = 40,
   parameter int EXP_WIDTH  = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic                  a_sign,
   input  logic                  b_sign,
   input  logic [EXP_WIDTH-1:0]  a_exp,
   input  logic [EXP_WIDTH-1:0]  b_exp,
   input  logic [FRAC_WIDTH-1:0] a_frac,
   input  logic [FRAC_WIDTH-1:0] b_frac,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [FRAC_WIDTH-1:0] elarge_op,
   output logic [FRAC_WIDTH-1:0] esmall_op,
   output logic [EXP_WIDTH-1:0]  exp_f,
   output logic [EXP_WIDTH:0]    diff_abs,
   output logic                  sign_diff,
   output logic                  sign_res,
   output logic                  near_sel
);

   localparam logic [EXP_WIDTH:0] DIFF_ONE = 1;

   // Handshake: a stage advances when it is empty or its consumer advances;
   // a transfer happens on a rising edge where valid and ready are both 1.
   logic                  s2_adv, s1_adv;

   logic                  s1_valid_q, s1_valid_d;
   logic                  s1_a_sign_q, s1_a_sign_d, s1_b_sign_q, s1_b_sign_d;
   logic [EXP_WIDTH-1:0]  s1_a_exp_q, s1_a_exp_d, s1_b_exp_q, s1_b_exp_d;
   logic [FRAC_WIDTH-1:0] s1_a_frac_q, s1_a_frac_d, s1_b_frac_q, s1_b_frac_d;
   logic                  s1_sdiff_q, s1_sdiff_d;
   logic [EXP_WIDTH:0]    s1_ediff_q, s1_ediff_d;

   logic                  s2_valid_q, s2_valid_d;
   logic [FRAC_WIDTH-1:0] s2_large_q, s2_large_d, s2_small_q, s2_small_d;
   logic [EXP_WIDTH-1:0]  s2_exp_q, s2_exp_d;
   logic [EXP_WIDTH:0]    s2_dabs_q, s2_dabs_d;
   logic                  s2_sdiff_q, s2_sdiff_d;
   logic                  s2_sres_q, s2_sres_d;
   logic                  s2_near_q, s2_near_d;

   logic                  exp_eq, frac_eq, swap;
   logic [EXP_WIDTH:0]    dabs;

   assign s2_adv   = !s2_valid_q || out_ready;
   assign s1_adv   = !s1_valid_q || s2_adv;
   assign in_ready = s1_adv;

   // Magnitude compare on the registered S1 operands.
   always_comb begin
      exp_eq  = (s1_ediff_q == '0);
      frac_eq = (s1_a_frac_q == s1_b_frac_q);
      swap    = s1_ediff_q[EXP_WIDTH] || (exp_eq && (s1_b_frac_q > s1_a_frac_q));
      dabs    = s1_ediff_q[EXP_WIDTH] ? ('0 - s1_ediff_q) : s1_ediff_q;
   end

   always_comb begin
      s1_valid_d  = s1_valid_q;
      s1_a_sign_d = s1_a_sign_q;
      s1_b_sign_d = s1_b_sign_q;
      s1_a_exp_d  = s1_a_exp_q;
      s1_b_exp_d  = s1_b_exp_q;
      s1_a_frac_d = s1_a_frac_q;
      s1_b_frac_d = s1_b_frac_q;
      s1_sdiff_d  = s1_sdiff_q;
      s1_ediff_d  = s1_ediff_q;
      if (s1_adv) begin
         s1_valid_d = in_valid;
         if (in_valid) begin
            s1_a_sign_d = a_sign;
            s1_b_sign_d = b_sign;
            s1_a_exp_d  = a_exp;
            s1_b_exp_d  = b_exp;
            s1_a_frac_d = a_frac;
            s1_b_frac_d = b_frac;
            s1_sdiff_d  = a_sign ^ b_sign;
            s1_ediff_d  = {1'b0, a_exp} - {1'b0, b_exp};
         end
      end
   end

   // S2 clears its data when it advances with nothing behind it, so idle outputs read 0.
   always_comb begin
      s2_valid_d = s2_valid_q;
      s2_large_d = s2_large_q;
      s2_small_d = s2_small_q;
      s2_exp_d   = s2_exp_q;
      s2_dabs_d  = s2_dabs_q;
      s2_sdiff_d = s2_sdiff_q;
      s2_sres_d  = s2_sres_q;
      s2_near_d  = s2_near_q;
      if (s2_adv) begin
         s2_valid_d = s1_valid_q;
         s2_large_d = '0;
         s2_small_d = '0;
         s2_exp_d   = '0;
         s2_dabs_d  = '0;
         s2_sdiff_d = 1'b0;
         s2_sres_d  = 1'b0;
         s2_near_d  = 1'b0;
         if (s1_valid_q) begin
            s2_large_d = swap ? s1_b_frac_q : s1_a_frac_q;
            s2_small_d = swap ? s1_a_frac_q : s1_b_frac_q;
            s2_exp_d   = swap ? s1_b_exp_q : s1_a_exp_q;
            s2_dabs_d  = dabs;
            s2_sdiff_d = s1_sdiff_q;
            s2_sres_d  = (s1_sdiff_q && exp_eq && frac_eq) ? 1'b0
                         : (swap ? s1_b_sign_q : s1_a_sign_q);
            s2_near_d  = s1_sdiff_q && (dabs <= DIFF_ONE);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid_q  <= 1'b0;
         s1_a_sign_q <= 1'b0;
         s1_b_sign_q <= 1'b0;
         s1_a_exp_q  <= '0;
         s1_b_exp_q  <= '0;
         s1_a_frac_q <= '0;
         s1_b_frac_q <= '0;
         s1_sdiff_q  <= 1'b0;
         s1_ediff_q  <= '0;
         s2_valid_q  <= 1'b0;
         s2_large_q  <= '0;
         s2_small_q  <= '0;
         s2_exp_q    <= '0;
         s2_dabs_q   <= '0;
         s2_sdiff_q  <= 1'b0;
         s2_sres_q   <= 1'b0;
         s2_near_q   <= 1'b0;
      end else begin
         s1_valid_q  <= s1_valid_d;
         s1_a_sign_q <= s1_a_sign_d;
         s1_b_sign_q <= s1_b_sign_d;
         s1_a_exp_q  <= s1_a_exp_d;
         s1_b_exp_q  <= s1_b_exp_d;
         s1_a_frac_q <= s1_a_frac_d;
         s1_b_frac_q <= s1_b_frac_d;
         s1_sdiff_q  <= s1_sdiff_d;
         s1_ediff_q  <= s1_ediff_d;
         s2_valid_q  <= s2_valid_d;
         s2_large_q  <= s2_large_d;
         s2_small_q  <= s2_small_d;
         s2_exp_q    <= s2_exp_d;
         s2_dabs_q   <= s2_dabs_d;
         s2_sdiff_q  <= s2_sdiff_d;
         s2_sres_q   <= s2_sres_d;
         s2_near_q   <= s2_near_d;
      end
   end

   assign out_valid = s2_valid_q;
   assign elarge_op = s2_large_q;
   assign esmall_op = s2_small_q;
   assign exp_f     = s2_exp_q;
   assign diff_abs  = s2_dabs_q;
   assign sign_diff = s2_sdiff_q;
   assign sign_res  = s2_sres_q;
   assign near_sel  = s2_near_q;

endmodule

// File: tb/tb_fadd_prep_n40.sv
// Bench for fadd_prep_n40: directed and random operand pairs, back-pressure, mid-flight reset,
// with an expected-result queue filled at input acceptance and drained at output transfer.
module tb_fadd_prep_n40;

   localparam int FW = 40;
   localparam int EW = 8;
   localparam int RW = FW + FW + EW + (EW + 1) + 3;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic          a_sign = 1'b0, b_sign = 1'b0;
   logic [EW-1:0] a_exp = '0, b_exp = '0;
   logic [FW-1:0] a_frac = '0, b_frac = '0;
   logic          out_valid;
   logic          out_ready = 1'b1;
   logic [FW-1:0] elarge_op, esmall_op;
   logic [EW-1:0] exp_f;
   logic [EW:0]   diff_abs;
   logic          sign_diff, sign_res, near_sel;

   logic [RW-1:0] exp_q[$];
   int            acc_q[$];
   int            n_cmp = 0;
   int            n_err = 0;
   int            cyc = 0;
   int            stall_acc = 0;
   logic          chk_lat = 1'b0;
   logic          expect_ready = 1'b0;

   fadd_prep_n40 #(.FRAC_WIDTH(FW), .EXP_WIDTH(EW)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .a_sign(a_sign), .b_sign(b_sign),
      .a_exp(a_exp), .b_exp(b_exp),
      .a_frac(a_frac), .b_frac(b_frac),
      .out_valid(out_valid), .out_ready(out_ready),
      .elarge_op(elarge_op), .esmall_op(esmall_op),
      .exp_f(exp_f), .diff_abs(diff_abs),
      .sign_diff(sign_diff), .sign_res(sign_res), .near_sel(near_sel)
   );

   // clock / reset
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [RW-1:0] model(input logic sa, input logic [EW-1:0] ea,
                                           input logic [FW-1:0] fa, input logic sb,
                                           input logic [EW-1:0] eb, input logic [FW-1:0] fb);
      int ia, ib, d;
      logic sw, sd, sr, nr;
      logic [FW-1:0] lg, sm;
      logic [EW-1:0] ef;
      logic [EW:0] dv;
      ia = int'(ea);
      ib = int'(eb);
      sw = (ib > ia) || ((ia == ib) && (fb > fa));
      d  = (ia > ib) ? ia - ib : ib - ia;
      dv = d[EW:0];
      lg = sw ? fb : fa;
      sm = sw ? fa : fb;
      ef = sw ? eb : ea;
      sd = sa ^ sb;
      sr = (sd && (ia == ib) && (fa == fb)) ? 1'b0 : (sw ? sb : sa);
      nr = sd && (d <= 1);
      return {lg, sm, ef, dv, sd, sr, nr};
   endfunction

   // driver: hold the pair until accepted, record expectation at the accepting cycle
   task automatic send(input logic sa, input logic [EW-1:0] ea, input logic [FW-1:0] fa,
                       input logic sb, input logic [EW-1:0] eb, input logic [FW-1:0] fb);
      bit done = 0;
      in_valid = 1'b1;
      a_sign = sa; a_exp = ea; a_frac = fa;
      b_sign = sb; b_exp = eb; b_frac = fb;
      for (int k = 0; k < 100 && !done; k++) begin
         @(negedge clk);
         if (k == 0 && expect_ready) check_eq("in_ready_stream", in_ready, 1);
         if (in_ready) begin
            exp_q.push_back(model(sa, ea, fa, sb, eb, fb));
            acc_q.push_back(cyc);
            if (!out_ready) stall_acc++;
            done = 1;
         end
         @(posedge clk);
         #1;
      end
      if (!done) check_eq("accept_timeout", in_ready, 1);
      in_valid = 1'b0;
   endtask

   task automatic send_rand();
      logic [EW-1:0] ea, eb;
      logic [FW-1:0] fa, fb;
      ea = EW'($urandom_range(0, 255));
      eb = ($urandom_range(0, 3) == 0) ? ea : EW'($urandom_range(0, 255));
      if ($urandom_range(0, 4) == 0) eb = ea + 8'd1;
      fa = {8'h80 | 8'($urandom_range(0, 255)), $urandom};
      fb = ($urandom_range(0, 5) == 0) ? fa : {8'h80 | 8'($urandom_range(0, 255)), $urandom};
      send(1'($urandom_range(0, 1)), ea, fa, 1'($urandom_range(0, 1)), eb, fb);
   endtask

   task automatic drain();
      for (int k = 0; k < 50 && exp_q.size() != 0; k++) @(negedge clk);
      check_eq("drain_empty", exp_q.size(), 0);
      @(posedge clk);
      #1;
   endtask

   // scoreboard: compare every presented set against the queue head (covers hold under stall)
   always @(negedge clk) begin
      if (!rst && out_valid) begin
         if (exp_q.size() == 0) begin
            check_eq("spurious_out", out_valid, 0);
         end else begin
            check_eq("out_set", {elarge_op, esmall_op, exp_f, diff_abs, sign_diff, sign_res,
                                 near_sel}, exp_q[0]);
            if (out_ready) begin
               if (chk_lat) check_eq("latency", cyc - acc_q[0], 2);
               void'(exp_q.pop_front());
               void'(acc_q.pop_front());
            end
         end
      end
   end

   initial begin
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check_eq("rst_out_valid", out_valid, 0);
      check_eq("rst_in_ready", in_ready, 1);
      check_eq("rst_data_zero", {elarge_op, esmall_op, exp_f, diff_abs, sign_diff, sign_res,
                                 near_sel}, 0);
      @(posedge clk);
      #1;

      // directed cases with free-running output
      chk_lat = 1'b1;
      send(1'b0, 8'd10, 40'h80_0000_0000, 1'b0, 8'd7, 40'hC0_0000_0000);
      drain();
      send(1'b0, 8'd5, 40'h80_0000_0000, 1'b1, 8'd6, 40'h90_0000_0000);
      drain();
      send(1'b1, 8'd20, 40'hA5_1234_5678, 1'b0, 8'd20, 40'hA5_1234_5678);
      drain();
      send(1'b1, 8'd255, 40'hA5_1234_5678, 1'b0, 8'd0, 40'hA5_1234_5678);
      drain();
      send(1'b0, 8'd0, 40'h80_0000_0000, 1'b1, 8'd255, 40'hFF_FFFF_FFFF);
      send(1'b1, 8'd9, 40'h80_0000_0001, 1'b0, 8'd9, 40'h80_0000_0002);
      drain();

      // back-to-back random stream: one accept and one result per cycle
      expect_ready = 1'b1;
      for (int i = 0; i < 24; i++) send_rand();
      expect_ready = 1'b0;
      drain();
      chk_lat = 1'b0;

      // six pairs with the output stalled in cycles 3-7
      stall_acc = 0;
      fork
         for (int i = 0; i < 6; i++) send_rand();
         begin
            out_ready = 1'b1;
            repeat (2) @(posedge clk);
            #1 out_ready = 1'b0;
            repeat (5) @(posedge clk);
            #1 out_ready = 1'b1;
         end
      join
      check_eq("stall_accepts", stall_acc, 0);
      drain();

      // random back-pressure
      fork
         for (int i = 0; i < 20; i++) send_rand();
         for (int i = 0; i < 60; i++) begin
            @(posedge clk);
            #1 out_ready = 1'($urandom_range(0, 1));
         end
      join
      out_ready = 1'b1;
      drain();

      // reset with both stages full
      out_ready = 1'b0;
      send_rand();
      send_rand();
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      exp_q.delete();
      acc_q.delete();
      @(negedge clk);
      check_eq("rst_full_out_valid", out_valid, 0);
      check_eq("rst_full_in_ready", in_ready, 1);
      check_eq("rst_full_data_zero", {elarge_op, esmall_op, exp_f, diff_abs, sign_diff,
                                      sign_res, near_sel}, 0);
      @(posedge clk);
      #1 out_ready = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      chk_lat = 1'b1;
      for (int i = 0; i < 3; i++) send_rand();
      drain();
      repeat (5) @(posedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
